// File: rtl/mux_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_pkg
// Purpose  : Shared definitions for the stream multiplexer family: mode
//            encodings and default word width / channel count. Later mux
//            variants import the same package so that the encodings stay
//            consistent across the family.
// Revision : 1.0 - initial release
// ============================================================================
package mux_stream_pkg;

    // Values of the 1-bit mode input.
    localparam logic c_mode_select = 1'b0;
    localparam logic c_mode_rr     = 1'b1;

    // Default geometry, matching the fixed 16:1 x 32-bit mux this replaces.
    localparam int c_default_width = 32;
    localparam int c_default_n     = 16;

endpackage : mux_stream_pkg
`default_nettype wire

// File: rtl/mux_stream_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Scans the request vector
//            starting at ptr and returns the first requesting index. The
//            scan wraps at N, not at 2^SEL_W.
// Ports    : req   in  N      request vector
//            ptr   in  SEL_W  scan start index
//            found out 1      at least one request is set
//            idx   out SEL_W  index of the granted request (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Walk the offsets from last to first so that the smallest offset
    // from ptr overwrites any later candidate and wins.
    always_comb begin
        int w_k;
        found = 1'b0;
        idx   = '0;
        w_k   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = int'(ptr) + i;
            // ptr + i is below 2^SEL_W + N, which is under 3N, so two
            // conditional subtractions always bring it back below N.
            if (w_k >= N) w_k = w_k - N;
            if (w_k >= N) w_k = w_k - N;
            if (req[w_k[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = w_k[SEL_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream
// Purpose  : Registered N-channel valid/ready stream multiplexer. One input
//            channel is chosen by an external index (SELECT mode) or by
//            round-robin arbitration, and its word is captured in a single
//            output register that honours consumer backpressure.
// Ports    : clock      in  1        rising-edge clock
//            reset_n    in  1        synchronous active-low reset
//            mode       in  1        0 = SELECT, 1 = ROUND_ROBIN
//            select     in  SEL_W    channel index for SELECT mode
//            in_valid   in  N        per-channel valid
//            in_data    in  N*WIDTH  flattened channel words
//            in_ready   out N        per-channel ready (one-hot or zero)
//            out_valid  out 1        output register holds a word
//            out_ready  in  1        consumer accepts the word
//            out_data   out WIDTH    registered word
//            out_chan   out SEL_W    channel that supplied out_data
// Revision : 1.0 - initial release
// ============================================================================
module mux_stream
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int N     = c_default_n,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     select,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan
);

    logic [SEL_W-1:0] r_ptr;
    logic             w_free;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_sel_in_range;
    logic             w_grant_ok;
    logic [SEL_W-1:0] w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_grant_data;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (r_ptr),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    assign w_free         = !out_valid || out_ready;
    assign w_sel_in_range = (32'(select) < N);

    // Grant depends only on current inputs and ptr, so mode/select changes
    // take effect in the same cycle.
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant    = '0;
        if (mode == c_mode_select) begin
            if (w_sel_in_range && in_valid[select]) begin
                w_grant_ok = 1'b1;
                w_grant    = select;
            end
        end else begin
            w_grant_ok = w_rr_found;
            w_grant    = w_rr_idx;
        end
    end

    // A grant implies the granted channel is valid, so a free register and
    // a grant is exactly a handshake. Reset suppresses every handshake.
    assign w_xfer = reset_n && w_free && w_grant_ok;

    always_comb begin
        in_ready = '0;
        if (w_xfer) in_ready[w_grant] = 1'b1;
    end

    // Constant-offset mux keeps every part-select static.
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SEL_W'(k)) w_grant_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_xfer) begin
                out_valid <= 1'b1;
                out_data  <= w_grant_data;
                out_chan  <= w_grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Only round-robin transfers advance the pointer; it wraps at
            // N so it never points at a nonexistent channel.
            if (w_xfer && (mode == c_mode_rr)) begin
                r_ptr <= (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

endmodule : mux_stream
`default_nettype wire

// File: tb/tb_mux_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_stream
// Purpose  : Directed self-checking bench for mux_stream with three
//            instances: N=16, N=5 and N=12, all WIDTH=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_stream;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- N = 16 ----------------
    logic          rst16, mode16, ordy16, ov16;
    logic [3:0]    sel16, oc16;
    logic [15:0]   iv16, ir16;
    logic [16*W-1:0] id16;
    logic [W-1:0]  od16;

    mux_stream #(.WIDTH(W), .N(16)) u_d16 (
        .clock(clk), .reset_n(rst16), .mode(mode16), .select(sel16),
        .in_valid(iv16), .in_data(id16), .in_ready(ir16),
        .out_valid(ov16), .out_ready(ordy16), .out_data(od16), .out_chan(oc16)
    );

    // ---------------- N = 5 ----------------
    logic          rst5, mode5, ordy5, ov5;
    logic [2:0]    sel5, oc5;
    logic [4:0]    iv5, ir5;
    logic [5*W-1:0] id5;
    logic [W-1:0]  od5;

    mux_stream #(.WIDTH(W), .N(5)) u_d5 (
        .clock(clk), .reset_n(rst5), .mode(mode5), .select(sel5),
        .in_valid(iv5), .in_data(id5), .in_ready(ir5),
        .out_valid(ov5), .out_ready(ordy5), .out_data(od5), .out_chan(oc5)
    );

    // ---------------- N = 12 ----------------
    logic          rst12, mode12, ordy12, ov12;
    logic [3:0]    sel12, oc12;
    logic [11:0]   iv12, ir12;
    logic [12*W-1:0] id12;
    logic [W-1:0]  od12;

    mux_stream #(.WIDTH(W), .N(12)) u_d12 (
        .clock(clk), .reset_n(rst12), .mode(mode12), .select(sel12),
        .in_valid(iv12), .in_data(id12), .in_ready(ir12),
        .out_valid(ov12), .out_ready(ordy12), .out_data(od12), .out_chan(oc12)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst16 = 1'b0; mode16 = 1'b0; sel16 = '0; iv16 = '1; ordy16 = 1'b1; id16 = '0;
        rst5  = 1'b0; mode5  = 1'b1; sel5  = '0; iv5  = 5'b10010; ordy5 = 1'b1; id5 = '0;
        rst12 = 1'b0; mode12 = 1'b0; sel12 = '0; iv12 = '1; ordy12 = 1'b1; id12 = '0;
        for (int k = 0; k < 16; k++) id16[k*W +: W] = 32'(k);
        for (int k = 0; k < 5;  k++) id5[k*W +: W]  = 32'hA0 + 32'(k);
        for (int k = 0; k < 12; k++) id12[k*W +: W] = 32'hC00 + 32'(k);

        @(negedge clk);
        // in_ready is forced low while reset is asserted.
        chk("rst_in_ready16", 64'(ir16), 64'h0);
        step();
        chk("rst_out_valid16", 64'(ov16), 64'h0);
        chk("rst_out_data16",  64'(od16), 64'h0);
        chk("rst_out_chan16",  64'(oc16), 64'h0);
        chk("rst_out_valid5",  64'(ov5),  64'h0);
        chk("rst_out_valid12", 64'(ov12), 64'h0);

        // ---- SELECT sweep on N=16 ----
        rst16 = 1'b1;
        for (int s = 0; s < 16; s++) begin
            sel16 = 4'(s);
            #1;
            chk($sformatf("sel_in_ready_%0d", s), 64'(ir16), 64'(16'(1) << s));
            step();
            chk($sformatf("sel_data_%0d", s),  64'(od16), 64'(s));
            chk($sformatf("sel_chan_%0d", s),  64'(oc16), 64'(s));
            chk($sformatf("sel_valid_%0d", s), 64'(ov16), 64'h1);
        end

        // ---- Round-robin fairness on N=16 (ptr still 0) ----
        mode16 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk($sformatf("rr_in_ready_%0d", i), 64'(ir16), 64'(16'(1) << (i % 16)));
            step();
            chk($sformatf("rr_chan_%0d", i), 64'(oc16), 64'(i % 16));
            chk($sformatf("rr_data_%0d", i), 64'(od16), 64'(i % 16));
        end

        // ---- Sparse requests with wrap on N=5: channels 1 and 4 ----
        rst5 = 1'b1;
        begin
            logic [2:0] exp_g [4];
            exp_g[0] = 3'd1; exp_g[1] = 3'd4; exp_g[2] = 3'd1; exp_g[3] = 3'd4;
            for (int i = 0; i < 4; i++) begin
                #1;
                chk($sformatf("n5_in_ready_%0d", i), 64'(ir5), 64'(5'(1) << exp_g[i]));
                step();
                chk($sformatf("n5_chan_%0d", i), 64'(oc5), 64'(exp_g[i]));
                chk($sformatf("n5_data_%0d", i), 64'(od5), 64'(32'hA0 + 32'(exp_g[i])));
            end
        end

        // ---- Backpressure on N=16 ----
        mode16 = 1'b0;
        sel16  = 4'd3;
        id16[3*W +: W] = 32'hDEADBEEF;
        step();
        chk("bp_load_data", 64'(od16), 64'hDEADBEEF);
        ordy16 = 1'b0;
        sel16  = 4'd5;
        id16[5*W +: W] = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", i), 64'(ir16), 64'h0);
            step();
            chk($sformatf("bp_hold_data_%0d", i),  64'(od16), 64'hDEADBEEF);
            chk($sformatf("bp_hold_chan_%0d", i),  64'(oc16), 64'h3);
            chk($sformatf("bp_hold_valid_%0d", i), 64'(ov16), 64'h1);
        end
        ordy16 = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(ir16), 64'h20);
        step();
        chk("bp_release_data",  64'(od16), 64'h12345678);
        chk("bp_release_chan",  64'(oc16), 64'h5);
        chk("bp_release_valid", 64'(ov16), 64'h1);

        // ---- Out-of-range select on N=12 ----
        rst12 = 1'b1;
        sel12 = 4'd2;
        step();
        chk("oor_load_valid", 64'(ov12), 64'h1);
        chk("oor_load_data",  64'(od12), 64'hC02);
        sel12 = 4'd13;
        #1;
        chk("oor_in_ready", 64'(ir12), 64'h0);
        step();
        chk("oor_drain_valid", 64'(ov12), 64'h0);
        chk("oor_keep_data",   64'(od12), 64'hC02);
        chk("oor_keep_chan",   64'(oc12), 64'h2);
        chk("oor_in_ready_2",  64'(ir12), 64'h0);

        // ---- Reset mid-stream on N=16 (ptr was 2 before reset) ----
        ordy16 = 1'b0;
        mode16 = 1'b1;
        iv16   = 16'b0000_0000_0000_1010;
        rst16  = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(ir16), 64'h0);
        step();
        chk("mid_rst_valid", 64'(ov16), 64'h0);
        chk("mid_rst_data",  64'(od16), 64'h0);
        chk("mid_rst_chan",  64'(oc16), 64'h0);
        rst16  = 1'b1;
        ordy16 = 1'b1;
        #1;
        chk("mid_rr_in_ready", 64'(ir16), 64'h2);
        step();
        chk("mid_rr_chan",  64'(oc16), 64'h1);
        chk("mid_rr_data",  64'(od16), 64'h1);
        chk("mid_rr_valid", 64'(ov16), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_stream
`default_nettype wire
